bnn_xnor_popcount_layer: RTL and testbench

- Fully binarised layer that consumes the OUT_WIDTH-bit sign vector produced by the upstream 8-bit hybrid layer, and its done flag.
- Computes XNOR-popcount dot products against binary weights, PARALLEL_BITS inputs per cycle, one neuron at a time.
- Emits a binarised output vector plus a done flag, in the same style as the upstream layer, so layers can be chained.
- Binary weights are loaded through a write port, so the bench can program them and no file path is needed.

---
 rtl/bnn_pkg.sv | 21 ++
 rtl/xnor_popcount_chunk.sv | 24 ++
 rtl/bnn_xnor_popcount_layer.sv | 134 +++++++++++++
 tb/tb_bnn_xnor_popcount_layer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
`default_nettype none
// bnn_pkg: shared state encoding, default layer sizes and width helper for the binarised layer.
package bnn_pkg;

  localparam int DEF_IN_WIDTH      = 128;
  localparam int DEF_OUT_WIDTH     = 64;
  localparam int DEF_PARALLEL_BITS = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Accumulator must hold the full count IN_WIDTH, hence the extra bit.
  function automatic int pop_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xnor_popcount_chunk.sv
`default_nettype none
// xnor_popcount_chunk: combinational count of matching activation/weight bits in one chunk.
module xnor_popcount_chunk #(
  parameter  int PARALLEL_BITS = 32,
  localparam int CNT_W         = $clog2(PARALLEL_BITS) + 1
) (
  input  logic [PARALLEL_BITS-1:0] act,
  input  logic [PARALLEL_BITS-1:0] wt,
  output logic [CNT_W-1:0]         count
);

  logic [PARALLEL_BITS-1:0] match;

  assign match = ~(act ^ wt);

  always_comb begin
    count = '0;
    for (int i = 0; i < PARALLEL_BITS; i++) begin
      count = count + CNT_W'(match[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bnn_xnor_popcount_layer.sv
`default_nettype none
// bnn_xnor_popcount_layer: XNOR-popcount binarised layer, one neuron at a time, PARALLEL_BITS per cycle.
// Define BNN_THRESHOLD_EN for programmable per-neuron thresholds (default: fixed IN_WIDTH/2).
module bnn_xnor_popcount_layer
  import bnn_pkg::*;
#(
  parameter  int IN_WIDTH      = DEF_IN_WIDTH,
  parameter  int OUT_WIDTH     = DEF_OUT_WIDTH,
  parameter  int PARALLEL_BITS = DEF_PARALLEL_BITS,
  localparam int CHUNKS        = IN_WIDTH / PARALLEL_BITS,
  localparam int POP_WIDTH     = pop_width(IN_WIDTH),
  localparam int WT_AW         = $clog2(OUT_WIDTH * CHUNKS),
  localparam int NEURON_W      = $clog2(OUT_WIDTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [IN_WIDTH-1:0]      in_bits,
  output logic                     in_ready,
  input  logic                     wt_we,
  input  logic [WT_AW-1:0]         wt_addr,
  input  logic [PARALLEL_BITS-1:0] wt_data,
  input  logic                     thr_we,
  input  logic [NEURON_W-1:0]      thr_addr,
  input  logic [POP_WIDTH-1:0]     thr_data,
  output logic [OUT_WIDTH-1:0]     out,
  output logic                     done
);

  localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int PC_W    = $clog2(PARALLEL_BITS) + 1;
  localparam logic [WT_AW:0] WT_DEPTH_V = (WT_AW + 1)'(OUT_WIDTH * CHUNKS);

  state_t                   state, state_nx;
  logic [IN_WIDTH-1:0]      in_buf;
  logic [NEURON_W-1:0]      neuron_idx;
  logic [CHUNK_W-1:0]       chunk_idx;
  logic [POP_WIDTH-1:0]     acc, next_acc, thr_cur;
  logic [PC_W-1:0]          pc;
  logic [PARALLEL_BITS-1:0] wt_mem [OUT_WIDTH * CHUNKS];
  logic [PARALLEL_BITS-1:0] wt_word, act_word;
  logic [WT_AW-1:0]         wt_rd_addr;
  logic                     accept, last_chunk, last_neuron;

  assign in_ready    = (state != S_RUN);
  assign accept      = in_valid && in_ready;
  assign last_chunk  = (chunk_idx == CHUNK_W'(CHUNKS - 1));
  assign last_neuron = (neuron_idx == NEURON_W'(OUT_WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: if (accept) state_nx = S_RUN;
      S_RUN:          if (last_chunk && last_neuron) state_nx = S_DONE;
      default:        state_nx = S_IDLE;
    endcase
  end

  // Weight RAM is deliberately left out of reset so programmed weights survive it.
  always_ff @(posedge clk) begin
    if (wt_we && (state != S_RUN) && ({1'b0, wt_addr} < WT_DEPTH_V)) begin
      wt_mem[wt_addr] <= wt_data;
    end
  end

  assign wt_rd_addr = WT_AW'(neuron_idx) * WT_AW'(CHUNKS) + WT_AW'(chunk_idx);
  assign wt_word    = wt_mem[wt_rd_addr];
  assign act_word   = in_buf[int'(chunk_idx) * PARALLEL_BITS +: PARALLEL_BITS];

  xnor_popcount_chunk #(
    .PARALLEL_BITS(PARALLEL_BITS)
  ) u_chunk (
    .act  (act_word),
    .wt   (wt_word),
    .count(pc)
  );

  assign next_acc = acc + POP_WIDTH'(pc);

`ifdef BNN_THRESHOLD_EN
  logic [POP_WIDTH-1:0] thr_mem [OUT_WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < OUT_WIDTH; n++) thr_mem[n] <= POP_WIDTH'(IN_WIDTH / 2);
    end else if (thr_we && (state != S_RUN)) begin
      thr_mem[thr_addr] <= thr_data;
    end
  end

  assign thr_cur = thr_mem[neuron_idx];
`else
  logic unused_thr;
  assign unused_thr = ^{thr_we, thr_addr, thr_data};
  assign thr_cur    = POP_WIDTH'(IN_WIDTH / 2);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_buf     <= '0;
      out        <= '0;
      done       <= 1'b0;
      neuron_idx <= '0;
      chunk_idx  <= '0;
      acc        <= '0;
    end else if (accept) begin
      in_buf     <= in_bits;
      out        <= '0;
      done       <= 1'b0;
      neuron_idx <= '0;
      chunk_idx  <= '0;
      acc        <= '0;
    end else if (state == S_RUN) begin
      if (!last_chunk) begin
        acc       <= next_acc;
        chunk_idx <= chunk_idx + 1'b1;
      end else begin
        // Unsigned count >= IN_WIDTH/2 is the same as a signed +/-1 dot product >= 0.
        out[neuron_idx] <= (next_acc >= thr_cur);
        acc             <= '0;
        chunk_idx       <= '0;
        if (last_neuron) done       <= 1'b1;
        else             neuron_idx <= neuron_idx + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bnn_xnor_popcount_layer.sv
`default_nettype none
// tb_bnn_xnor_popcount_layer: directed self-checking bench, IN_WIDTH=16, OUT_WIDTH=4, PARALLEL_BITS=4.
module tb_bnn_xnor_popcount_layer;

  localparam int IW = 16;
  localparam int OW = 4;
  localparam int PB = 4;

  logic        clk = 1'b0;
  logic        reset, in_valid, wt_we, thr_we;
  logic [15:0] in_bits;
  logic [3:0]  wt_addr, wt_data;
  logic [1:0]  thr_addr;
  logic [4:0]  thr_data;
  logic        in_ready, done;
  logic [3:0]  out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bnn_xnor_popcount_layer #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .PARALLEL_BITS(PB)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bits(in_bits), .in_ready(in_ready),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .thr_we(thr_we), .thr_addr(thr_addr), .thr_data(thr_data),
    .out(out), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_w(input int addr, input logic [3:0] data);
    @(negedge clk);
    wt_we = 1'b1; wt_addr = 4'(addr); wt_data = data;
    @(negedge clk);
    wt_we = 1'b0;
  endtask

  task automatic set_neuron(input int n, input logic [15:0] w);
    for (int c = 0; c < 4; c++) wr_w(n * 4 + c, w[c*4 +: 4]);
  endtask

  task automatic fill_all(input logic [15:0] w);
    for (int n = 0; n < 4; n++) set_neuron(n, w);
  endtask

  task automatic accept(input logic [15:0] bits);
    @(negedge clk);
    in_valid = 1'b1; in_bits = bits;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until done; optionally disturbs inputs mid-run.
  task automatic wait_done(input string tag, input logic [3:0] exp, input bit pulse);
    int cyc = 0;
    bit ready_low = 1'b1;
    while (!done && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      if (!done && in_ready) ready_low = 1'b0;
      if (pulse && cyc == 5) begin
        in_valid = 1'b1; in_bits = ~in_bits;
        wt_we = 1'b1; wt_addr = 4'd0; wt_data = 4'h0;
      end
      if (pulse && cyc == 7) begin
        in_valid = 1'b0; wt_we = 1'b0;
      end
    end
    check({tag, " latency"}, cyc, 16);
    check({tag, " done"}, {31'd0, done}, 1);
    check({tag, " out"}, {28'd0, out}, {28'd0, exp});
    check({tag, " ready_low_in_run"}, {31'd0, ready_low}, 1);
    repeat (3) @(posedge clk);
    #1;
    check({tag, " done_sticky"}, {31'd0, done}, 1);
    check({tag, " out_stable"}, {28'd0, out}, {28'd0, exp});
    check({tag, " ready_in_done"}, {31'd0, in_ready}, 1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_bits = '0;
    wt_we = 1'b0; wt_addr = '0; wt_data = '0;
    thr_we = 1'b0; thr_addr = '0; thr_data = '0;
    #12;
    check("rst out", {28'd0, out}, 0);
    check("rst done", {31'd0, done}, 0);
    check("rst ready", {31'd0, in_ready}, 1);
    @(negedge clk);
    reset = 1'b0;

    // All-ones weights: full match, exact threshold, one below threshold.
    fill_all(16'hFFFF);
    accept(16'hFFFF);
    wait_done("t1_ffff", 4'b1111, 1'b0);
    accept(16'h00FF);
    wait_done("t2_00ff", 4'b1111, 1'b0);
    accept(16'h007F);
    wait_done("t2_007f", 4'b0000, 1'b0);

    // Distinct weights per neuron: pops 0,16,8,8.
    set_neuron(0, 16'hFFFF);
    set_neuron(1, 16'h0000);
    set_neuron(2, 16'hAAAA);
    set_neuron(3, 16'h5555);
    accept(16'h0000);
    wait_done("t3_0000", 4'b1110, 1'b0);

    // Pops 16,0,8,8; mid-run accept attempt and weight write must be ignored.
    accept(16'hFFFF);
    wait_done("t4_pulse", 4'b1101, 1'b1);
    accept(16'h00FF);
    wait_done("t4_wt_kept", 4'b1111, 1'b0);

    // Reset during RUN after neuron 0 has already produced a 1.
    accept(16'hFFFF);
    repeat (7) @(posedge clk);
    #1;
    check("t5 partial out", {28'd0, out}, 1);
    reset = 1'b1;
    #1;
    check("t5 rst out", {28'd0, out}, 0);
    check("t5 rst done", {31'd0, done}, 0);
    check("t5 rst ready", {31'd0, in_ready}, 1);
    @(negedge clk);
    reset = 1'b0;
    accept(16'hFFFF);
    wait_done("t5_after_rst", 4'b1101, 1'b0);

    // Weight write in the accept cycle is seen from the first RUN cycle.
    fill_all(16'hFFFF);
    @(negedge clk);
    in_valid = 1'b1; in_bits = 16'h00FF;
    wt_we = 1'b1; wt_addr = 4'd0; wt_data = 4'h0;
    @(posedge clk); #1;
    in_valid = 1'b0; wt_we = 1'b0;
    wait_done("t6_same_cycle_wr", 4'b1110, 1'b0);

    // Threshold of neuron 2 raised to 12; input pop is 11.
    wr_w(0, 4'hF);
    @(negedge clk);
    thr_we = 1'b1; thr_addr = 2'd2; thr_data = 5'd12;
    @(negedge clk);
    thr_we = 1'b0;
    accept(16'h07FF);
`ifdef BNN_THRESHOLD_EN
    wait_done("t7_thr", 4'b1011, 1'b0);
`else
    wait_done("t7_thr", 4'b1111, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
